// File: rtl/multicycle_ctrl.sv
// Multicycle main controller FSM with ALU decoder and memory-ready stalls.
// Optional retired-instruction counter is built only when INSTR_CNT_EN is defined.
module multicycle_ctrl #(
  parameter int STATE_W = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  Op,
  input  logic [5:0]  Funct,
  input  logic [3:0]  Rd,
  input  logic        mem_ready,
  output logic        PCS,
  output logic        RegW,
  output logic        MemW,
  output logic [1:0]  FlagW,
  output logic        NextPC,
  output logic        IRWrite,
  output logic        AdrSrc,
  output logic [1:0]  ResultSrc,
  output logic        ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic [1:0]  ALUControl,
  output logic [1:0]  ImmSrc,
  output logic [1:0]  RegSrc,
  output logic [31:0] instr_count
);

  // state    | meaning
  // FETCH    | read instruction at PC, PC+4 (waits on mem_ready)
  // DECODE   | read registers, dispatch on Op
  // MEMADR   | compute load/store address
  // MEMREAD  | load data access (waits on mem_ready)
  // MEMWB    | write loaded data to Rd
  // MEMWRITE | store data access (waits on mem_ready)
  // EXECUTER | ALU op, register operand
  // EXECUTEI | ALU op, immediate operand
  // ALUWB    | write ALU result to Rd
  // BRANCH   | branch target to PC
  typedef enum logic [STATE_W-1:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB,
    S_MEMWRITE, S_EXECUTER, S_EXECUTEI, S_ALUWB, S_BRANCH
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic        w_alu_op;
  logic        w_branch;
  logic        w_regw;
  logic        w_memw;
  logic        w_nextpc;
  logic        w_irwrite;
  logic        w_adr_src;
  logic [1:0]  w_result_src;
  logic        w_src_a;
  logic [1:0]  w_src_b;
  logic [1:0]  w_alu_ctrl;
  logic [1:0]  w_flag_w;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_FETCH;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next       = S_FETCH;
    w_alu_op     = 1'b0;
    w_branch     = 1'b0;
    w_regw       = 1'b0;
    w_memw       = 1'b0;
    w_nextpc     = 1'b0;
    w_irwrite    = 1'b0;
    w_adr_src    = 1'b0;
    w_result_src = 2'b00;
    w_src_a      = 1'b0;
    w_src_b      = 2'b00;
    case (r_state)
      S_FETCH: begin
        w_src_a      = 1'b1;
        w_src_b      = 2'b10;
        w_result_src = 2'b10;
        w_irwrite    = mem_ready;
        w_nextpc     = mem_ready;
        w_next       = mem_ready ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        w_src_a      = 1'b1;
        w_src_b      = 2'b10;
        w_result_src = 2'b10;
        case (Op)
          2'b01:   w_next = S_MEMADR;
          2'b00:   w_next = Funct[5] ? S_EXECUTEI : S_EXECUTER;
          2'b10:   w_next = S_BRANCH;
          default: w_next = S_FETCH;
        endcase
      end
      S_MEMADR: begin
        w_src_b = 2'b01;
        w_next  = Funct[0] ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        w_adr_src = 1'b1;
        w_next    = mem_ready ? S_MEMWB : S_MEMREAD;
      end
      S_MEMWB: begin
        w_result_src = 2'b01;
        w_regw       = 1'b1;
        w_next       = S_FETCH;
      end
      S_MEMWRITE: begin
        w_adr_src = 1'b1;
        w_memw    = mem_ready;
        w_next    = mem_ready ? S_FETCH : S_MEMWRITE;
      end
      S_EXECUTER: begin
        w_alu_op = 1'b1;
        w_next   = S_ALUWB;
      end
      S_EXECUTEI: begin
        w_src_b  = 2'b01;
        w_alu_op = 1'b1;
        w_next   = S_ALUWB;
      end
      S_ALUWB: begin
        w_regw = 1'b1;
        w_next = S_FETCH;
      end
      S_BRANCH: begin
        w_src_b      = 2'b01;
        w_result_src = 2'b10;
        w_branch     = 1'b1;
        w_next       = S_FETCH;
      end
      default: w_next = S_FETCH;
    endcase
  end

  // Unrecognised cmd values neither compute nor touch flags.
  always_comb begin
    w_alu_ctrl = 2'b00;
    w_flag_w   = 2'b00;
    if (w_alu_op) begin
      case (Funct[4:1])
        4'b0100: begin w_alu_ctrl = 2'b00; w_flag_w = {Funct[0], Funct[0]}; end
        4'b0010: begin w_alu_ctrl = 2'b01; w_flag_w = {Funct[0], Funct[0]}; end
        4'b0000: begin w_alu_ctrl = 2'b10; w_flag_w = {Funct[0], 1'b0};     end
        4'b1100: begin w_alu_ctrl = 2'b11; w_flag_w = {Funct[0], 1'b0};     end
        default: begin w_alu_ctrl = 2'b00; w_flag_w = 2'b00;                end
      endcase
    end
  end

  assign PCS        = reset & (((Rd == 4'd15) & w_regw) | w_branch);
  assign RegW       = reset & w_regw;
  assign MemW       = reset & w_memw;
  assign FlagW      = {2{reset}} & w_flag_w;
  assign NextPC     = reset & w_nextpc;
  assign IRWrite    = reset & w_irwrite;
  assign AdrSrc     = w_adr_src;
  assign ResultSrc  = w_result_src;
  assign ALUSrcA    = w_src_a;
  assign ALUSrcB    = w_src_b;
  assign ALUControl = w_alu_ctrl;
  assign ImmSrc     = Op;
  assign RegSrc     = {Op == 2'b01, Op == 2'b10};

`ifdef INSTR_CNT_EN
  logic        w_retire;
  logic [31:0] r_instr_count;

  // An instruction retires on the edge that returns the FSM to FETCH.
  always_comb begin
    w_retire = (r_state == S_MEMWB) || (r_state == S_ALUWB) || (r_state == S_BRANCH) ||
               ((r_state == S_MEMWRITE) && mem_ready) ||
               ((r_state == S_DECODE) && (Op == 2'b11));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)        r_instr_count <= '0;
    else if (w_retire) r_instr_count <= r_instr_count + 32'd1;
  end

  assign instr_count = r_instr_count;
`else
  assign instr_count = '0;
`endif

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Multicycle main controller FSM plus ALU decoder. Produces the unconditioned write requests PCS, RegW, MemW and FlagW that the condition-logic stage gates with CondEx.
- Also drives all datapath mux selects, IRWrite and NextPC. Sits between the instruction register (Op/Funct/Rd) and the condition logic.
- Supports a memory ready handshake so that fetch and data accesses can stall.

Parameters:
- STATE_W, 4, width of the state register (10 states used).

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- Op  input  2  instruction [27:26].
- Funct  input  6  instruction [25:20]: I, cmd[3:0], S/L.
- Rd  input  4  destination register.
- mem_ready  input  1  memory completes the current access this cycle.
- PCS  output  1  PC-write request: (Rd==15 & RegW) | Branch.
- RegW  output  1  register write request.
- MemW  output  1  memory write request.
- FlagW  output  2  flag write enables: [1]=NZ, [0]=CV.
- NextPC  output  1  unconditional PC update (fetch).
- IRWrite  output  1  instruction register load.
- AdrSrc  output  1  0=PC, 1=ALU result.
- ResultSrc  output  2  00=ALUOut, 01=Data, 10=ALU direct.
- ALUSrcA  output  1  0=RD1, 1=PC.
- ALUSrcB  output  2  00=RD2, 01=ExtImm, 10=const 4.
- ALUControl  output  2  00 ADD, 01 SUB, 10 AND, 11 ORR.
- ImmSrc  output  2  equals Op.
- RegSrc  output  2  [0]=(Op==10), [1]=(Op==01).
- instr_count  output  32  retired-instruction count (see Optional Feature).

Behaviour:
- Reset (reset=0, asynchronous): state=FETCH. Registered outputs clear and instr_count=0.
- While reset is asserted, all strobes (PCS, RegW, MemW, FlagW, NextPC, IRWrite) are forced to 0.
- Outputs are Moore-decoded from state, except the strobes listed below, which also depend on mem_ready.
- Unlisted selects in each state are 0.
- Transitions:
  - FETCH: AdrSrc=0, ALUSrcA=1, ALUSrcB=10, ResultSrc=10, ALUOp=0. IRWrite and NextPC are asserted only in a cycle where mem_ready=1. Goes to DECODE when mem_ready=1, else holds.
  - DECODE: ALUSrcA=1, ALUSrcB=10, ResultSrc=10. Next state by Op:
    - Op=01 -> MEMADR.
    - Op=00 with Funct[5]=0 -> EXECUTER.
    - Op=00 with Funct[5]=1 -> EXECUTEI.
    - Op=10 -> BRANCH.
    - Op=11 -> FETCH (undefined opcode, no writes, counts as retired).
  - MEMADR: ALUSrcA=0, ALUSrcB=01, ALUOp=0. Goes to MEMREAD if Funct[0]=1, else MEMWRITE.
  - MEMREAD: AdrSrc=1, ResultSrc=00. Goes to MEMWB when mem_ready=1, else holds.
  - MEMWB: ResultSrc=01, RegW=1. Goes to FETCH.
  - MEMWRITE: AdrSrc=1, ResultSrc=00. MemW=1 only in the mem_ready=1 cycle. Goes to FETCH on mem_ready, else holds.
  - EXECUTER: ALUSrcA=0, ALUSrcB=00, ALUOp=1. Goes to ALUWB.
  - EXECUTEI: ALUSrcA=0, ALUSrcB=01, ALUOp=1. Goes to ALUWB.
  - ALUWB: ResultSrc=00, RegW=1. Goes to FETCH.
  - BRANCH: ALUSrcA=0, ALUSrcB=01, ResultSrc=10, Branch=1. Goes to FETCH.
- ALU decoder:
  - ALUOp=0: ALUControl=00, FlagW=00.
  - ALUOp=1: Funct[4:1] selects 0100 ADD, 0010 SUB, 0000 AND, 1100 ORR. Any other value gives ALUControl=00 and FlagW=00.
  - For a legal cmd: FlagW[1]=Funct[0], and FlagW[0]=Funct[0] & (ADD or SUB).
- Latency: ALU op 4 cycles, STR 4, LDR 5, B 3, all with mem_ready tied 1. Each mem_ready=0 cycle adds one.
- Illegal state encodings go to FETCH on the next clock.
- Reset mid-instruction aborts the instruction with no strobe and no count.

Optional Feature:
- Macro INSTR_CNT_EN.
- Defined: instr_count increments by 1 (mod 2^32, wraps) on every transition into FETCH from MEMWB, MEMWRITE, ALUWB, BRANCH or DECODE(Op=11).
- Undefined: instr_count is constant 0 and no counter flops are generated.

Test Plan:
- ADD R1,R2,R3 with S=1 (Op=00, Funct=001001, Rd=1), mem_ready=1 -> states FETCH, DECODE, EXECUTER, ALUWB. ALUControl=00 and FlagW=11 in EXECUTER; RegW=1 and PCS=0 in ALUWB; back in FETCH at cycle 4.
- LDR (Op=01, Funct[0]=1) with mem_ready low 2 cycles in MEMREAD -> MEMREAD held 3 cycles, then MEMWB with RegW=1, ResultSrc=01. Total 7 cycles.
- STR (Funct[0]=0) with mem_ready low 1 cycle in FETCH -> IRWrite/NextPC=0 while stalled and 1 for exactly one cycle. In MEMWRITE, MemW=1 once and RegW=0 throughout.
- B (Op=10) -> BRANCH with PCS=1, ALUSrcB=01; 3 cycles total. ORR into R15 (Rd=15, Funct[4:1]=1100) -> PCS=1 and RegW=1 in ALUWB, ALUControl=11.
- Undefined Funct[4:1]=1111 with S=1 -> FlagW=00, ALUControl=00. Op=11 -> DECODE to FETCH with no strobes.
- reset driven 0 asynchronously during MEMREAD -> state FETCH immediately, all strobes 0. With INSTR_CNT_EN, instr_count=0; after 3 ADDs it is 3. A preload near 0xFFFFFFFF wraps to 0.
